// File: rtl/ram_arbiter_pkg.sv
// Shared types for the two-master block-RAM port arbiter.
// Optional grant locking is enabled with RAM_ARBITER_LOCK_EN.
package ram_arbiter_pkg;

  localparam int NUM_MASTERS = 2;
  localparam int DEF_ADDR_W  = 9;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_BE_W    = DEF_DATA_W / 8;

  typedef logic master_idx_t;

  typedef struct packed {
    logic [DEF_BE_W-1:0]   we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; owns the last-grant and lock state.
// Grant locking is compiled in with RAM_ARBITER_LOCK_EN.
module rr_arbiter2
  import ram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
`ifdef RAM_ARBITER_LOCK_EN
  input  logic [1:0] lock,
`endif
  output logic [1:0] gnt
);

  master_idx_t r_last;

`ifdef RAM_ARBITER_LOCK_EN
  logic r_held;
  logic w_keep;

  // the previous owner keeps the port while it holds lock and valid
  assign w_keep = r_held & req[r_last] & lock[r_last];
`endif

  always_comb begin
    gnt = '0;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_last ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
`ifdef RAM_ARBITER_LOCK_EN
    if (w_keep) begin
      gnt = r_last ? 2'b10 : 2'b01;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= 1'b1;
`ifdef RAM_ARBITER_LOCK_EN
      r_held <= 1'b0;
`endif
    end else begin
      if (advance) begin
        r_last <= gnt[1];
      end
`ifdef RAM_ARBITER_LOCK_EN
      r_held <= advance;
`endif
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one block-RAM port between m0 (CPU) and m1 (debug/loader).
// Build with RAM_ARBITER_LOCK_EN to add m0_lock/m1_lock grant locking.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    m0_valid,
  output logic                    m0_ready,
  input  logic [DATA_WIDTH/8-1:0] m0_we,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  output logic                    m0_rsp_valid,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
`ifdef RAM_ARBITER_LOCK_EN
  input  logic                    m0_lock,
  input  logic                    m1_lock,
`endif
  input  logic                    m1_valid,
  output logic                    m1_ready,
  input  logic [DATA_WIDTH/8-1:0] m1_we,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  output logic                    m1_rsp_valid,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic [DATA_WIDTH/8-1:0] ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  input  logic [DATA_WIDTH-1:0]   ram_rdata
);

  localparam int BE_W = DATA_WIDTH / 8;

  logic [1:0]            w_req;
  logic [1:0]            w_gnt;
  logic                  w_adv;
  logic [BE_W-1:0]       w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_rsp0;
  logic                  w_rsp1;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_pend;
  master_idx_t           r_owner;

  // masking requests keeps ready and ram_we low through reset
  assign w_req = {m1_valid, m0_valid} & {2{~reset}};
  assign w_adv = |w_gnt;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (w_req),
    .advance (w_adv),
`ifdef RAM_ARBITER_LOCK_EN
    .lock    ({m1_lock, m0_lock}),
`endif
    .gnt     (w_gnt)
  );

  assign m0_ready = w_gnt[0];
  assign m1_ready = w_gnt[1];

  always_comb begin
    w_we    = '0;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    unique case (1'b1)
      w_gnt[0]: begin
        w_we    = m0_we;
        w_addr  = m0_addr;
        w_wdata = m0_wdata;
      end
      w_gnt[1]: begin
        w_we    = m1_we;
        w_addr  = m1_addr;
        w_wdata = m1_wdata;
      end
      default: ;
    endcase
  end

  assign ram_we    = w_we;
  assign ram_addr  = w_addr;
  assign ram_wdata = w_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_pend  <= 1'b0;
      r_owner <= 1'b0;
    end else begin
      if (w_adv) begin
        r_addr  <= w_addr;
        r_wdata <= w_wdata;
      end
      r_pend  <= w_adv;
      r_owner <= w_gnt[1];
    end
  end

  // a response still in flight when reset rises is dropped
  assign w_rsp0 = r_pend & ~r_owner & ~reset;
  assign w_rsp1 = r_pend &  r_owner & ~reset;

  assign m0_rsp_valid = w_rsp0;
  assign m1_rsp_valid = w_rsp1;
  assign m0_rdata     = w_rsp0 ? ram_rdata : '0;
  assign m1_rdata     = w_rsp1 ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomised scoreboard bench for ram_arbiter with a behavioural RAM.
// Lock scenarios are exercised when RAM_ARBITER_LOCK_EN is defined.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_valid, m1_valid;
  logic          m0_ready, m1_ready;
  logic [BW-1:0] m0_we, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_rsp_valid, m1_rsp_valid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_lock, m1_lock;
  logic [BW-1:0] ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .m0_valid     (m0_valid),
    .m0_ready     (m0_ready),
    .m0_we        (m0_we),
    .m0_addr      (m0_addr),
    .m0_wdata     (m0_wdata),
    .m0_rsp_valid (m0_rsp_valid),
    .m0_rdata     (m0_rdata),
`ifdef RAM_ARBITER_LOCK_EN
    .m0_lock      (m0_lock),
    .m1_lock      (m1_lock),
`endif
    .m1_valid     (m1_valid),
    .m1_ready     (m1_ready),
    .m1_we        (m1_we),
    .m1_addr      (m1_addr),
    .m1_wdata     (m1_wdata),
    .m1_rsp_valid (m1_rsp_valid),
    .m1_rdata     (m1_rdata),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  always #5 clk = ~clk;

  // read-first byte-write block RAM
  logic [DW-1:0] mem [0:511];
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    for (int b = 0; b < BW; b++)
      if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int            m;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] ref_mem [0:511];
  int            last;
  int            prev_g;
  req_t          rq [2];
  bit            pend [2];
  bit            lk [2];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  function automatic req_t rnd_req();
    req_t r;
    r.we    = ($urandom % 2) ? 4'($urandom) : 4'h0;
    r.addr  = 9'($urandom % 16);
    r.wdata = $urandom;
    return r;
  endfunction

  task automatic drive();
    m0_valid = pend[0];
    m0_we    = rq[0].we;
    m0_addr  = rq[0].addr;
    m0_wdata = rq[0].wdata;
    m1_valid = pend[1];
    m1_we    = rq[1].we;
    m1_addr  = rq[1].addr;
    m1_wdata = rq[1].wdata;
    m0_lock  = lk[0];
    m1_lock  = lk[1];
  endtask

  // one clock: predict the grant, check the RAM port, log the response
  task automatic step();
    int            g;
    logic [1:0]    er;
    logic [AW-1:0] a;
    @(negedge clk);
    g = -1;
    if (!reset) begin
      if (pend[0] && pend[1]) begin
        g = (last == 1) ? 0 : 1;
`ifdef RAM_ARBITER_LOCK_EN
        if (prev_g >= 0 && lk[prev_g]) g = prev_g;
`endif
      end else if (pend[0]) g = 0;
      else if (pend[1]) g = 1;
    end
    er = (g < 0) ? 2'b00 : (g == 0 ? 2'b01 : 2'b10);
    chk("ready", {30'd0, m1_ready, m0_ready}, {30'd0, er});
    chk("ram_we", {28'd0, ram_we},
        (g < 0) ? 32'd0 : {28'd0, rq[g].we});
    if (g >= 0) begin
      a = rq[g].addr;
      chk("ram_addr", {23'd0, ram_addr}, {23'd0, a});
      chk("ram_wdata", ram_wdata, rq[g].wdata);
      q.push_back('{g, ref_mem[a], cyc + 1});
      for (int b = 0; b < BW; b++)
        if (rq[g].we[b]) ref_mem[a][8*b +: 8] = rq[g].wdata[8*b +: 8];
      last = g;
      pend[g] = 0;
    end
    prev_g = g;
    if (reset) begin
      last = 1;
      prev_g = -1;
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  // response monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_rsp", {30'd0, m1_rsp_valid, m0_rsp_valid}, 32'd0);
        chk("rst_rdata0", m0_rdata, 32'd0);
        chk("rst_rdata1", m1_rdata, 32'd0);
        q.delete();
      end else if (m0_rsp_valid || m1_rsp_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected: got rsp {%b,%b} expected none",
                   m1_rsp_valid, m0_rsp_valid);
        end else begin
          e = q.pop_front();
          chk("rsp_who", {30'd0, m1_rsp_valid, m0_rsp_valid},
              (e.m == 0) ? 32'd1 : 32'd2);
          chk("rsp_cycle", cyc, e.cyc);
          chk("rsp_data", (e.m == 0) ? m0_rdata : m1_rdata, e.data);
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        failures++;
        $display("FAIL rsp_missing: got none expected m%0d rsp %h",
                 e.m, e.data);
      end
    end
  end

  initial begin
    reset = 1'b1;
    last = 1;
    prev_g = -1;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0;
      lk[i] = 0;
      rq[i] = '0;
    end
    for (int i = 0; i < 512; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[5] = 32'hDEADBEEF;
    ref_mem[5] = 32'hDEADBEEF;
    mem[16] = 32'hAAAAAAAA;
    ref_mem[16] = 32'hAAAAAAAA;
    drive();
    step();
    step();
    reset = 1'b0;

    // m0 read of preloaded word
    pend[0] = 1;
    rq[0] = '{we: 4'h0, addr: 9'h005, wdata: 32'h0};
    drive();
    step();
    step();

    // m1 partial write then read back
    pend[1] = 1;
    rq[1] = '{we: 4'b0011, addr: 9'h010, wdata: 32'h0000_1234};
    drive();
    step();
    pend[1] = 1;
    rq[1] = '{we: 4'h0, addr: 9'h010, wdata: 32'h0};
    drive();
    step();
    step();

    // continuous conflict
    for (int i = 0; i < 6; i++) begin
      for (int m = 0; m < 2; m++)
        if (!pend[m]) begin
          pend[m] = 1;
          rq[m] = rnd_req();
        end
      drive();
      step();
    end
    for (int m = 0; m < 2; m++) pend[m] = 0;
    drive();
    step();

    // reset right after an acceptance
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1;
      rq[m] = rnd_req();
    end
    drive();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1;
      rq[m] = rnd_req();
    end
    drive();
    step();
    step();
    step();

`ifdef RAM_ARBITER_LOCK_EN
    pend[1] = 1;
    lk[1] = 1;
    rq[1] = rnd_req();
    drive();
    step();
    for (int i = 0; i < 3; i++) begin
      pend[0] = 1;
      rq[0] = (i == 0) ? rnd_req() : rq[0];
      pend[1] = 1;
      rq[1] = rnd_req();
      drive();
      step();
    end
    lk[1] = 0;
    pend[1] = 1;
    rq[1] = rnd_req();
    drive();
    step();
    step();
    step();
`endif

    // idle
    for (int m = 0; m < 2; m++) begin
      pend[m] = 0;
      lk[m] = 0;
    end
    drive();
    for (int i = 0; i < 4; i++) step();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && ($urandom % 4 != 0)) begin
          pend[m] = 1;
          rq[m] = rnd_req();
        end
`ifdef RAM_ARBITER_LOCK_EN
        lk[m] = ($urandom % 3 == 0);
`endif
      end
      drive();
      step();
    end

    for (int m = 0; m < 2; m++) begin
      pend[m] = 0;
      lk[m] = 0;
    end
    drive();
    step();
    step();
    step();
    chk("queue_drained", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one port of the dual-port byte-write block RAM between two requesters: m0 (CPU data access) and m1 (debug/loader).
- Each requester uses a valid/ready request channel and receives a one-cycle-later response strobe.
- Round-robin arbitration; at most one RAM access per cycle.
- Sits between the requesters and the RAM port; drives we/addr/wdata and captures rdata.

Parameters:
- ADDR_WIDTH, 9, RAM word-address width.
- DATA_WIDTH, 32, data width; must be a multiple of 8.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- m0_valid  in  1  m0 request valid.
- m0_ready  out  1  m0 request accepted this cycle.
- m0_we  in  DATA_WIDTH/8  m0 byte write enables; all zero means read.
- m0_addr  in  ADDR_WIDTH  m0 word address.
- m0_wdata  in  DATA_WIDTH  m0 write data.
- m0_rsp_valid  out  1  m0 response; pulses one cycle after acceptance.
- m0_rdata  out  DATA_WIDTH  m0 read data; valid while m0_rsp_valid is high.
- m1_* : the same seven signals for m1.
- ram_we  out  DATA_WIDTH/8  to RAM byte write enables.
- ram_addr  out  ADDR_WIDTH  to RAM address.
- ram_wdata  out  DATA_WIDTH  to RAM write data.
- ram_rdata  in  DATA_WIDTH  from RAM, registered, one-cycle latency.

Behaviour:
- Arbitration is combinational each cycle:
  - Only one master valid: that master is granted.
  - Both valid: the master not granted most recently wins.
  - last_grant register updates on every grant; reset value 1, so m0 wins the first conflict.
- mN_ready = grant to N.
- Accepted request:
  - Its we/addr/wdata are driven onto the RAM port the same cycle.
  - With no grant, ram_we = 0; ram_addr and ram_wdata are don't-care, but are held at the last value.
- Response:
  - rsp_owner and rsp_pending registers record the accepted master.
  - The next cycle, that master's rsp_valid = 1 and mN_rdata = ram_rdata.
  - Writes also get rsp_valid; rdata is then the pre-write word, which the RAM returns read-first.
- Throughput: one access per cycle, no bubbles. Back-to-back grants to alternating masters are legal.
- Responses have no backpressure; requesters must sink them.
- Requester rule: after asserting valid, a requester holds addr/we/wdata stable until ready. The arbiter does not check this.
- Reset:
  - All outputs low: ready, rsp_valid, ram_we.
  - rdata outputs = 0.
  - rsp_pending cleared.
- Reset mid-operation: a pending response is dropped (no rsp_valid after reset). RAM contents are unaffected.
- Starvation bound: a continuously valid master is granted within 2 cycles.

Optional Feature:
- Macro: RAM_ARBITER_LOCK_EN.
- With the macro: extra inputs m0_lock and m1_lock, 1 bit each.
  - If the master granted last cycle has lock = 1 and valid = 1, it keeps the grant regardless of round-robin.
  - The lock ends when lock or valid drops.
  - Lock is sampled only while that master holds the grant. A lock from a non-owner is ignored until it wins normally.
- Without the macro: no lock ports; pure round-robin.

Decomposition:
- Package ram_arbiter_pkg:
  - typedef master_idx_t (logic, 1 bit).
  - localparam NUM_MASTERS = 2.
  - typedef struct req_t {we, addr, wdata}, parameterised via the package's default widths.
- One sub-module: rr_arbiter2.
  - Inputs: clk, reset, req[1:0], advance; optional lock input under the macro.
  - Output: one-hot gnt[1:0].
  - Owns last_grant and the lock state.
- The top level handles muxing and the response tracker.

Test Plan:
- Reset, then m0 read addr 0x005 (RAM preloaded 0xDEADBEEF): m0_ready the same cycle; next cycle m0_rsp_valid = 1, m0_rdata = 0xDEADBEEF; m1_rsp_valid stays 0.
- m1 writes we = 4'b0011, wdata 0x0000_1234 to addr 0x010 (old 0xAAAAAAAA), then m1 reads 0x010 -> rdata 0xAAAA1234.
- Both valid continuously for 6 cycles -> grants m0, m1, m0, m1, m0, m1; each rsp_valid appears exactly one cycle after the matching ready.
- Both requests valid, reset asserted in the cycle after the acceptance -> no rsp_valid after reset; the first post-reset conflict is granted to m0.
- RAM_ARBITER_LOCK_EN: m1 granted with lock = 1 for 4 cycles while m0 valid -> m1 granted 4 cycles in a row; the cycle after lock drops, m0 is granted.
- Idle cycles (no valid) -> ram_we = 0 and no rsp_valid pulses.
